// File: rtl/tm1638_serial_xfer.sv
// TM1638 serial master: multi-word writes under one STB, optional key-scan read; a word starts SPI activity one clock after accept.
// o_Busy stays high from the clock after accept until the word (or read phase and STB recovery) completes; offers while busy are dropped.
module tm1638_serial_xfer #(
    parameter int CYCLES      = 4,
    parameter int DATA_BITS   = 8,
    parameter int RD_BYTES    = 4,
    parameter int TURN_CYCLES = 8
) (
    input  logic                          i_Clk,
    input  logic                          i_Rst_n,
    output logic                          o_Busy,
    input  logic                          i_Data_Ready,
    input  logic [DATA_BITS-1:0]          i_Data,
    input  logic                          i_Last,
    input  logic                          i_Read,
    output logic                          o_Rd_Valid,
    output logic [DATA_BITS-1:0]          o_Rd_Data,
    output logic [$clog2(RD_BYTES):0]     o_Rd_Index,
    output logic                          o_SPI_Stb,
    output logic                          o_SPI_Clk,
    output logic                          o_SPI_Dio,
    output logic                          o_SPI_Dio_Oe,
    input  logic                          i_SPI_Dio,
    output logic [2:0]                    o_Diag_State,
    output logic [$clog2(DATA_BITS):0]    o_Diag_Bit
);

    localparam int MAXC = (CYCLES > TURN_CYCLES) ? CYCLES : TURN_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    localparam int BW   = $clog2(DATA_BITS) + 1;
    localparam int IW   = $clog2(RD_BYTES) + 1;

    localparam logic [CW-1:0] HALF_LAST = CW'(CYCLES - 1);
    localparam logic [CW-1:0] TURN_LAST = CW'(TURN_CYCLES - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
    localparam logic [IW-1:0] WORD_LAST = IW'(RD_BYTES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_SHIFT, S_GAP, S_TURN, S_READ, S_HOLD, S_RECOVER
    } state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic                 phase_q, phase_d;   // 0 = SPI clock low half of the cell
    logic [DATA_BITS-1:0] tx_q, tx_d;
    logic                 last_q, last_d;
    logic                 read_q, read_d;
    logic [DATA_BITS-1:0] rx_q, rx_d;
    logic [IW-1:0]        word_q, word_d;
    logic                 rd_valid_q, rd_valid_d;
    logic [DATA_BITS-1:0] rd_data_q, rd_data_d;
    logic [IW-1:0]        rd_index_q, rd_index_d;
    logic                 accept;
    logic                 half_done;

    always_comb begin
        o_Busy    = !((state_q == S_IDLE) || (state_q == S_GAP));
        accept    = i_Data_Ready && !o_Busy;
        half_done = (cnt_q == HALF_LAST);

        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        phase_d    = phase_q;
        tx_d       = tx_q;
        last_d     = last_q;
        read_d     = read_q;
        rx_d       = rx_q;
        word_d     = word_q;
        rd_valid_d = 1'b0;
        rd_data_d  = rd_data_q;
        rd_index_d = rd_index_q;

        case (state_q)
            S_IDLE, S_GAP: begin
                if (accept) begin
                    // From GAP the strobe is already low, so the setup phase is skipped.
                    state_d = (state_q == S_IDLE) ? S_SETUP : S_SHIFT;
                    cnt_d   = '0;
                    bit_d   = '0;
                    phase_d = 1'b0;
                    tx_d    = i_Data;
                    last_d  = i_Last | i_Read;
                    read_d  = i_Read;
                end
            end
            S_SETUP: begin
                if (half_done) begin
                    state_d = S_SHIFT;
                    cnt_d   = '0;
                    bit_d   = '0;
                    phase_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_SHIFT: begin
                if (half_done) begin
                    cnt_d   = '0;
                    phase_d = !phase_q;
                    if (phase_q) begin
                        tx_d = tx_q >> 1;
                        if (bit_q == BIT_LAST) begin
                            bit_d   = '0;
                            state_d = read_q ? S_TURN : (last_q ? S_HOLD : S_GAP);
                        end else begin
                            bit_d = bit_q + BW'(1);
                        end
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_TURN: begin
                if (cnt_q == TURN_LAST) begin
                    state_d = S_READ;
                    cnt_d   = '0;
                    bit_d   = '0;
                    phase_d = 1'b0;
                    word_d  = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_READ: begin
                if (half_done) begin
                    cnt_d   = '0;
                    phase_d = !phase_q;
                    if (!phase_q) begin
                        // LSB arrives first, so shift in from the top.
                        rx_d                = rx_q >> 1;
                        rx_d[DATA_BITS-1]   = i_SPI_Dio;
                    end else if (bit_q == BIT_LAST) begin
                        bit_d      = '0;
                        rd_valid_d = 1'b1;
                        rd_data_d  = rx_q;
                        rd_index_d = word_q;
                        word_d     = word_q + IW'(1);
                        if (word_q == WORD_LAST) begin
                            state_d = S_HOLD;
                        end
                    end else begin
                        bit_d = bit_q + BW'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_HOLD, S_RECOVER: begin
                if (half_done) begin
                    state_d = (state_q == S_HOLD) ? S_RECOVER : S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        o_SPI_Stb    = 1'b0;
        o_SPI_Clk    = 1'b1;
        o_SPI_Dio    = 1'b1;
        o_SPI_Dio_Oe = 1'b1;
        case (state_q)
            S_IDLE, S_RECOVER: o_SPI_Stb = 1'b1;
            S_SHIFT: begin
                o_SPI_Clk = phase_q;
                o_SPI_Dio = tx_q[0];
            end
            S_TURN:  o_SPI_Dio_Oe = 1'b0;
            S_READ: begin
                o_SPI_Dio_Oe = 1'b0;
                o_SPI_Clk    = phase_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            phase_q    <= 1'b0;
            tx_q       <= '0;
            last_q     <= 1'b0;
            read_q     <= 1'b0;
            rx_q       <= '0;
            word_q     <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            rd_index_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            phase_q    <= phase_d;
            tx_q       <= tx_d;
            last_q     <= last_d;
            read_q     <= read_d;
            rx_q       <= rx_d;
            word_q     <= word_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            rd_index_q <= rd_index_d;
        end
    end

    assign o_Rd_Valid   = rd_valid_q;
    assign o_Rd_Data    = rd_data_q;
    assign o_Rd_Index   = rd_index_q;
    assign o_Diag_State = state_q;
    assign o_Diag_Bit   = bit_q;

endmodule

// File: tb/tb_tm1638_serial_xfer.sv
// Bench for tm1638_serial_xfer: default build with an SPI-side scoreboard, plus a CYCLES=1/16-bit build.
module tb_tm1638_serial_xfer;
    localparam int DB = 8;
    localparam int RB = 4;

    typedef struct {
        logic [7:0] data;
        logic       last;
        logic       read;
        int         busy;
        int         falls;
        int         oe_low;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic       rdy, last, read, busy, rv, stb, sclk, sdio, oe, din;
    logic [7:0] data, rdata;
    logic [2:0] ridx, dstate;
    logic [3:0] dbit;

    logic        rdy2, last2, read2, busy2, rv2, stb2, sclk2, sdio2, oe2, din2;
    logic [15:0] data2, rdata2;
    logic [0:0]  ridx2;
    logic [2:0]  dstate2;
    logic [4:0]  dbit2;

    tm1638_serial_xfer dut (
        .i_Clk(clk), .i_Rst_n(rst_n), .o_Busy(busy), .i_Data_Ready(rdy), .i_Data(data),
        .i_Last(last), .i_Read(read), .o_Rd_Valid(rv), .o_Rd_Data(rdata), .o_Rd_Index(ridx),
        .o_SPI_Stb(stb), .o_SPI_Clk(sclk), .o_SPI_Dio(sdio), .o_SPI_Dio_Oe(oe), .i_SPI_Dio(din),
        .o_Diag_State(dstate), .o_Diag_Bit(dbit)
    );

    tm1638_serial_xfer #(.CYCLES(1), .DATA_BITS(16), .RD_BYTES(1), .TURN_CYCLES(8)) dut2 (
        .i_Clk(clk), .i_Rst_n(rst_n), .o_Busy(busy2), .i_Data_Ready(rdy2), .i_Data(data2),
        .i_Last(last2), .i_Read(read2), .o_Rd_Valid(rv2), .o_Rd_Data(rdata2), .o_Rd_Index(ridx2),
        .o_SPI_Stb(stb2), .o_SPI_Clk(sclk2), .o_SPI_Dio(sdio2), .o_SPI_Dio_Oe(oe2), .i_SPI_Dio(din2),
        .o_Diag_State(dstate2), .o_Diag_Bit(dbit2)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    // Reference model: every accepted word must appear on the pins LSB first; every read command returns RB bytes.
    logic [DB-1:0] exp_w [1024];
    logic [DB-1:0] rd_bytes [1024];
    logic [DB-1:0] pre [4];
    int wr_idx = 0, rb_wr = 0, acc_cnt = 0, exp_frames = 0, pre_ptr = 0, pre_cnt = 0;
    logic last_end = 1'b1;

    always @(posedge clk) begin
        if (rst_n && rdy && !busy) begin
            exp_w[wr_idx] = data;
            wr_idx++;
            acc_cnt++;
            last_end = last | read;
            if (last | read) exp_frames++;
            if (read) begin
                for (int k = 0; k < RB; k++) begin
                    if (pre_ptr < pre_cnt) begin
                        rd_bytes[rb_wr] = pre[pre_ptr];
                        pre_ptr++;
                    end else begin
                        rd_bytes[rb_wr] = DB'($urandom);
                    end
                    rb_wr++;
                end
            end
        end
    end

    // Pin monitor for the default build.
    int rd_idx = 0, rv_idx = 0, falls = 0, oe_low = 0, stb_rises = 0, bitn = 0;
    logic prev_clk = 1'b1, prev_stb = 1'b1, prev_rv = 1'b0;
    logic [DB-1:0] acc;

    always @(negedge clk) begin
        if (!rst_n) begin
            bitn     = 0;
            rd_idx   = wr_idx;
            rv_idx   = rb_wr;
            prev_clk = 1'b1;
            prev_stb = 1'b1;
            prev_rv  = 1'b0;
        end else begin
            if (!prev_clk && sclk && !stb && oe) begin
                acc[bitn] = sdio;
                bitn++;
                if (bitn == DB) begin
                    bitn = 0;
                    if (rd_idx < wr_idx) check("tx_word", 32'(acc), 32'(exp_w[rd_idx]));
                    else check("tx_unexpected_word", 32'(acc), 32'hFFFF_FFFF);
                    rd_idx++;
                end
            end
            if (prev_clk && !sclk) falls++;
            if (!oe) oe_low++;
            if (!prev_stb && stb) stb_rises++;
            if (rv) begin
                check("rd_valid_width", 32'(prev_rv), 32'd0);
                if (rv_idx < rb_wr) check("rd_data", 32'(rdata), 32'(rd_bytes[rv_idx]));
                else check("rd_unexpected", 32'(rdata), 32'hFFFF_FFFF);
                check("rd_index", 32'(ridx), 32'(rv_idx % RB));
                rv_idx++;
            end
            prev_clk = sclk;
            prev_stb = stb;
            prev_rv  = rv;
        end
    end

    // Key-scan device model: presents the next bit after each falling SPI clock while DIO is released.
    int drv_bit = 0;
    logic d_prev = 1'b1;
    always @(negedge clk) begin
        if (!rst_n) begin
            drv_bit = rb_wr * DB;
            d_prev  = 1'b1;
            din     = 1'b0;
        end else begin
            if (!oe && !sclk && d_prev) begin
                din = rd_bytes[drv_bit / DB][drv_bit % DB];
                drv_bit++;
            end
            d_prev = sclk;
        end
    end

    task automatic apply(input vec_t v, input string nm);
        int f0, o0, n;
        @(negedge clk);
        rdy  = 1'b1;
        data = v.data;
        last = v.last;
        read = v.read;
        f0   = falls;
        o0   = oe_low;
        @(negedge clk);
        rdy  = 1'b0;
        data = 8'($urandom);
        n = 0;
        while (busy && n < 3000) begin
            n++;
            @(negedge clk);
            data = 8'($urandom);
        end
        check({nm, "_busy_span"}, 32'(n), 32'(v.busy));
        check({nm, "_clk_pulses"}, 32'(falls - f0), 32'(v.falls));
        check({nm, "_oe_low"}, 32'(oe_low - o0), 32'(v.oe_low));
        check({nm, "_stb_after"}, 32'(stb), 32'(v.last | v.read));
    endtask

    vec_t tbl [9];
    logic stb_a [0:79], clk_a [0:79], dio_a [0:79], busy_a [0:79];

    initial begin
        logic [7:0]  w1;
        logic [15:0] w2v, r2v;
        logic [7:0]  cp;
        logic [3:0]  dp;
        int stb_low, rise0, frame0, acc0, cnt;
        logic done;

        tbl[0] = '{8'h40, 1'b1, 1'b0, 76, 8, 0};
        tbl[1] = '{8'hFF, 1'b1, 1'b0, 76, 8, 0};
        tbl[2] = '{8'hC0, 1'b0, 1'b0, 68, 8, 0};
        tbl[3] = '{8'h3F, 1'b0, 1'b0, 64, 8, 0};
        tbl[4] = '{8'h06, 1'b1, 1'b0, 72, 8, 0};
        tbl[5] = '{8'h42, 1'b1, 1'b1, 340, 40, 264};
        tbl[6] = '{8'h81, 1'b0, 1'b1, 340, 40, 264};
        tbl[7] = '{8'h55, 1'b0, 1'b0, 68, 8, 0};
        tbl[8] = '{8'h12, 1'b0, 1'b1, 336, 40, 264};

        rst_n = 1'b1;
        rdy = 1'b0; data = '0; last = 1'b0; read = 1'b0;
        rdy2 = 1'b0; data2 = '0; last2 = 1'b0; read2 = 1'b0; din2 = 1'b0;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_stb", 32'(stb), 32'd1);
        check("rst_clk", 32'(sclk), 32'd1);
        check("rst_dio", 32'(sdio), 32'd1);
        check("rst_oe", 32'(oe), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rd", {rv, rdata, ridx}, 32'd0);
        check("rst_diag", {dstate, dbit}, 32'd0);
        rst_n = 1'b1;

        // Single write of 0x40 with cycle-exact pin timing.
        w1 = 8'h40;
        @(negedge clk);
        rdy = 1'b1; data = w1; last = 1'b1; read = 1'b0;
        for (int n = 1; n <= 78; n++) begin
            @(negedge clk);
            rdy  = 1'b0;
            data = 8'($urandom);
            stb_a[n] = stb; clk_a[n] = sclk; dio_a[n] = sdio; busy_a[n] = busy;
        end
        stb_low = 0;
        for (int n = 1; n <= 72; n++) if (!stb_a[n]) stb_low++;
        check("w1_stb_low_cycles", 32'(stb_low), 32'd72);
        check("w1_stb_rise_t73", 32'(stb_a[73]), 32'd1);
        check("w1_busy_t76", 32'(busy_a[76]), 32'd1);
        check("w1_busy_t77", 32'(busy_a[77]), 32'd0);
        for (int b = 0; b < 8; b++) begin
            for (int k = 0; k < 8; k++) cp[k] = clk_a[5 + 8 * b + k];
            for (int k = 0; k < 4; k++) dp[k] = dio_a[5 + 8 * b + k];
            check($sformatf("w1_bit%0d_clk", b), 32'(cp), 32'h0F0);
            check($sformatf("w1_bit%0d_dio", b), 32'(dp), w1[b] ? 32'hF : 32'h0);
        end

        // Table: single writes, a three-word frame, reads (incl. read offered in GAP).
        pre[0] = 8'h01; pre[1] = 8'h10; pre[2] = 8'h00; pre[3] = 8'h80;
        pre_cnt = 4;
        rise0 = stb_rises;
        for (int i = 0; i < 9; i++) apply(tbl[i], $sformatf("tbl%0d", i));
        check("tbl_stb_rises", 32'(stb_rises - rise0), 32'd6);

        // Randomised traffic with Data_Ready held high and data churning every cycle.
        rise0  = stb_rises;
        frame0 = exp_frames;
        acc0   = acc_cnt;
        done   = 1'b0;
        for (int cyc = 0; cyc < 20000; cyc++) begin
            @(negedge clk);
            if ((acc_cnt - acc0) >= 30 && last_end) begin
                done = 1'b1;
                break;
            end
            rdy  = 1'b1;
            data = 8'($urandom);
            read = ($urandom_range(0, 7) == 0);
            last = ((acc_cnt - acc0) >= 30) ? 1'b1 : 1'($urandom_range(0, 1));
        end
        rdy = 1'b0; read = 1'b0;
        check("rand_finished", 32'(done), 32'd1);
        cnt = 0;
        while (dstate != 3'd0 && cnt < 3000) begin
            @(negedge clk);
            cnt++;
        end
        check("rand_idle", 32'(dstate), 32'd0);
        check("rand_stb_rises", 32'(stb_rises - rise0), 32'(exp_frames - frame0));
        check("rand_words_seen", 32'(rd_idx), 32'(wr_idx));
        check("rand_reads_seen", 32'(rv_idx), 32'(rb_wr));

        // Asynchronous reset during bit 3 of a write.
        @(negedge clk);
        rdy = 1'b1; data = 8'h77; last = 1'b1;
        @(negedge clk);
        rdy = 1'b0;
        cnt = 0;
        while (!(dstate == 3'd2 && dbit == 4'd3) && cnt < 200) begin
            @(negedge clk);
            cnt++;
        end
        check("abort_reached_bit3", 32'(dbit), 32'd3);
        rst_n = 1'b0;
        #1;
        check("abort_stb", 32'(stb), 32'd1);
        check("abort_clk", 32'(sclk), 32'd1);
        check("abort_oe", 32'(oe), 32'd1);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_no_pulse", 32'(rv), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        apply('{8'h5A, 1'b1, 1'b0, 76, 8, 0}, "post_abort");
        check("post_abort_words", 32'(rd_idx), 32'(wr_idx));

        // CYCLES=1, 16-bit word, single read byte.
        w2v = 16'hA5C3;
        r2v = 16'h3C96;
        @(negedge clk);
        rdy2 = 1'b1; data2 = w2v; read2 = 1'b1; last2 = 1'b0;
        for (int n = 1; n <= 76; n++) begin
            int b;
            @(negedge clk);
            rdy2  = 1'b0;
            data2 = 16'($urandom);
            if (n == 1) begin
                check("d2_setup", {stb2, sclk2}, 32'b01);
            end else if (n <= 33) begin
                b = (n - 2) / 2;
                check($sformatf("d2_tx%0d_clk", b), 32'(sclk2), 32'((n - 2) % 2));
                if ((n - 2) % 2 == 0) check($sformatf("d2_tx%0d_dio", b), 32'(sdio2), 32'(w2v[b]));
            end else if (n <= 41) begin
                check("d2_turn", {stb2, oe2, sclk2}, 32'b001);
            end else if (n <= 73) begin
                b = (n - 42) / 2;
                check($sformatf("d2_rx%0d_clk", b), {oe2, sclk2}, 32'((n - 42) % 2));
                if ((n - 42) % 2 == 0) din2 = r2v[b];
            end else if (n == 74) begin
                check("d2_rd_valid", 32'(rv2), 32'd1);
                check("d2_rd_data", 32'(rdata2), 32'(r2v));
                check("d2_rd_index", 32'(ridx2), 32'd0);
            end else if (n == 75) begin
                check("d2_single_pulse", 32'(rv2), 32'd0);
                check("d2_stb_recover", 32'(stb2), 32'd1);
            end else begin
                check("d2_idle", 32'(busy2), 32'd0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tm1638_serial_xfer.md
Name: tm1638_serial_xfer

Overview:
- Parametrised successor to the existing TM1638 write-only serial shifter.
- Adds:
  - configurable word width and clock divider;
  - multi-word transactions with STB held low across words;
  - a read phase with a turnaround wait and N returned bytes (key scan), using a tri-state DIO split into out, output-enable and in.
- Sits between the display/keypad controller FSM and the board pins; the controller feeds one word per handshake.

Parameters:
- CYCLES, 4, system clocks per SPI clock half-period (>=1).
- DATA_BITS, 8, bits per word, shifted LSB first (>=1).
- RD_BYTES, 4, words read after a read command (>=1).
- TURN_CYCLES, 8, system clocks with DIO released before the first read clock (>=1).

Ports:
- i_Clk  in  1  system clock.
- i_Rst_n  in  1  asynchronous active-low reset.
- o_Busy  out  1  high = word not accepted.
- i_Data_Ready  in  1  word valid; accepted when high and o_Busy low.
- i_Data  in  DATA_BITS  word to send.
- i_Last  in  1  with accepted word: release STB after it.
- i_Read  in  1  with accepted word: read phase follows (implies i_Last).
- o_Rd_Valid  out  1  one-cycle pulse per read word.
- o_Rd_Data  out  DATA_BITS  read word, valid with o_Rd_Valid, held until the next one.
- o_Rd_Index  out  $clog2(RD_BYTES)+1  index of the word in o_Rd_Data, from 0.
- o_SPI_Stb  out  1  strobe, active low.
- o_SPI_Clk  out  1  serial clock, idles high.
- o_SPI_Dio  out  1  serial data out.
- o_SPI_Dio_Oe  out  1  DIO output enable.
- i_SPI_Dio  in  1  DIO pin input.
- o_Diag_State  out  3  current state encoding.
- o_Diag_Bit  out  $clog2(DATA_BITS)+1  current bit index.

Behaviour:
- Reset (async assert, sync release to IDLE):
  - Stb=1, Clk=1, Dio=1, Oe=1;
  - Busy=0, Rd_Valid=0, Rd_Data=0, Rd_Index=0;
  - counters 0.
  - Reset mid-transfer aborts immediately with no completion pulse.
- States: IDLE, SETUP, SHIFT, GAP, TURN, READ, HOLD, RECOVER.
- IDLE: Busy=0. On accept (edge T) → SETUP; Busy=1 from T+1.
- SETUP: Stb=0, Clk=1 for CYCLES clocks → SHIFT.
- SHIFT bit cell (2*CYCLES clocks):
  - Clk=0 with Dio=data[bit] for CYCLES clocks;
  - then Clk=1 for CYCLES clocks.
  - Bits 0..DATA_BITS-1. Word latched at accept; input changes afterwards are ignored.
- After the last cell:
  - i_Read → TURN;
  - i_Last → HOLD;
  - else → GAP.
- GAP: Stb=0, Clk=1, Busy=0, waits indefinitely. Accept → SHIFT on the next cycle (no SETUP).
- TURN: Oe=0 for TURN_CYCLES clocks → READ.
- READ: same cell timing with Oe=0.
  - i_SPI_Dio is sampled on the last clock of each low phase into bit[bit].
  - After each word's final high phase: Rd_Valid=1 for 1 clock with Rd_Data and Rd_Index.
  - After RD_BYTES words → HOLD.
- HOLD: Oe=1, Dio=1, Stb=0, Clk=1 for CYCLES clocks.
- RECOVER: Stb=1, Busy=1 for CYCLES clocks → IDLE.
- Busy span for a single write word: (2*DATA_BITS+3)*CYCLES clocks.
- Data_Ready while Busy=1: ignored, with no queue.
- i_Read accepted in GAP: valid; read follows that word.
- i_Read with i_Last=0: treated as last.
- Counter widths sized for max(CYCLES, TURN_CYCLES); the bit counter saturates nowhere and wraps to 0 per word.

Test Plan:
- Single write (CYCLES=4, DATA_BITS=8): accept 0x40 with Last=1 at T → Stb low T+1..T+72; 8 Clk low pulses of 4 clocks each; Dio LSB first 0,0,0,0,0,0,1,0; Stb high at T+73; Busy low at T+77.
- Multi-word: 0xC0 (Last=0), then 0x3F and 0x06 (Last=1) → Stb stays low through both gaps; Busy=0 in GAP; 24 Clk pulses total; one Stb rise.
- Read: accept 0x42 with Read=1; bench drives DIO bytes 0x01, 0x10, 0x00, 0x80 → Oe low from the end of the command for 8 + 4*64 clocks; four Rd_Valid pulses with index 0..3 and matching data; Stb rises after HOLD.
- Backpressure: hold Data_Ready=1 and change i_Data every cycle while busy → only the word present at the accept edge is shifted; one transfer per handshake.
- Async reset mid-SHIFT of bit 3 → same cycle: Stb=1, Clk=1, Oe=1, Busy=0; a new accept afterwards transfers normally.
- Parameter sweep CYCLES=1, DATA_BITS=16, RD_BYTES=1 → bit cell is 2 clocks; 16 bits LSB first; a single Rd_Valid with index 0.
